// File: rtl/jtag_mon_pkg.sv
// Shared types and jdo field positions for the JTAG debug monitor bridge.
package jtag_mon_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    DONE = 2'd3
  } mon_state_e;

  localparam int         JDO_RDREQ_BIT = 34;
  localparam int         JDO_WDATA_LSB = 3;
  localparam int         JDO_ADDR_LSB  = 2;
  localparam logic [3:0] BYTEEN_ALL    = 4'hF;

endpackage

// File: rtl/jtag_mon_watchdog.sv
// Counts consecutive stalled bus cycles and pulses expire on the last allowed one.
module jtag_mon_watchdog
  import jtag_mon_pkg::*;
#(
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic clk,
  input  logic reset_n,
  input  logic active,
  input  logic stall,
  output logic expire
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  logic [CNT_W-1:0] stall_cnt;

  // Combinational so the owning FSM leaves the bus state on the same edge.
  assign expire = active && stall && (stall_cnt == CNT_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      stall_cnt <= '0;
    end else if (active && stall && !expire) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end else begin
      stall_cnt <= '0;
    end
  end

endmodule

// File: rtl/jtag_debug_mon_bridge.sv
// Turns JTAG debug strobes into single-word Avalon-MM reads/writes.
// Optional bus-stall watchdog enabled with `define JTAG_MON_TIMEOUT_EN.
module jtag_debug_mon_bridge
  import jtag_mon_pkg::*;
#(
  parameter int ADDR_W      = 16,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [37:0]       jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  input  logic              take_no_action_ocimem_a,
  output logic [31:0]       MonDReg,
  output logic              monitor_ready,
  output logic              monitor_error,
  output logic [ADDR_W+1:0] mon_address,
  output logic              mon_read,
  output logic              mon_write,
  output logic [31:0]       mon_writedata,
  output logic [3:0]        mon_byteenable,
  input  logic [31:0]       mon_readdata,
  input  logic              mon_waitrequest
);

  localparam logic [1:0] S_IDLE = IDLE;
  localparam logic [1:0] S_RD   = RD;
  localparam logic [1:0] S_WR   = WR;
  localparam logic [1:0] S_DONE = DONE;

  logic [1:0]        state;
  logic [ADDR_W-1:0] MonAReg;
  logic              inc_pend;
  logic              wd_expire;
  logic              unused_jdo_bits;

  assign mon_address     = {MonAReg, 2'b00};
  assign mon_writedata   = MonDReg;
  assign mon_byteenable  = BYTEEN_ALL;
  assign unused_jdo_bits = ^{jdo[37:35], jdo[1:0]};

`ifdef JTAG_MON_TIMEOUT_EN
  logic bus_busy;
  assign bus_busy = (state == S_RD) || (state == S_WR);

  jtag_mon_watchdog #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_watchdog (
    .clk    (clk),
    .reset_n(reset_n),
    .active (bus_busy),
    .stall  (mon_waitrequest),
    .expire (wd_expire)
  );
`else
  // Without the watchdog the stall limit has no effect; the bus is waited on forever.
  assign wd_expire = 1'b0 & (TIMEOUT_CYC == 0);
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state         <= S_IDLE;
      MonAReg       <= '0;
      MonDReg       <= '0;
      monitor_ready <= 1'b0;
      monitor_error <= 1'b0;
      mon_read      <= 1'b0;
      mon_write     <= 1'b0;
      inc_pend      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          // Write strobe wins over address load, which wins over read-next.
          if (take_action_ocimem_b) begin
            MonDReg       <= jdo[JDO_WDATA_LSB +: 32];
            monitor_ready <= 1'b0;
            monitor_error <= 1'b0;
            mon_write     <= 1'b1;
            inc_pend      <= 1'b1;
            state         <= S_WR;
          end else if (take_action_ocimem_a) begin
            MonAReg       <= jdo[JDO_ADDR_LSB +: ADDR_W];
            monitor_ready <= 1'b0;
            monitor_error <= 1'b0;
            inc_pend      <= 1'b0;
            if (jdo[JDO_RDREQ_BIT]) begin
              mon_read <= 1'b1;
              state    <= S_RD;
            end else begin
              state    <= S_DONE;
            end
          end else if (take_no_action_ocimem_a) begin
            monitor_ready <= 1'b0;
            monitor_error <= 1'b0;
            mon_read      <= 1'b1;
            inc_pend      <= 1'b1;
            state         <= S_RD;
          end
        end
        S_RD: begin
          if (wd_expire) begin
            mon_read      <= 1'b0;
            monitor_error <= 1'b1;
            inc_pend      <= 1'b0;
            state         <= S_DONE;
          end else if (!mon_waitrequest) begin
            MonDReg  <= mon_readdata;
            mon_read <= 1'b0;
            state    <= S_DONE;
          end
        end
        S_WR: begin
          if (wd_expire) begin
            mon_write     <= 1'b0;
            monitor_error <= 1'b1;
            inc_pend      <= 1'b0;
            state         <= S_DONE;
          end else if (!mon_waitrequest) begin
            mon_write <= 1'b0;
            state     <= S_DONE;
          end
        end
        S_DONE: begin
          monitor_ready <= 1'b1;
          if (inc_pend) begin
            MonAReg <= MonAReg + 1'b1;
          end
          inc_pend <= 1'b0;
          state    <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
